// File: rtl/gp_regfile_sb_if.sv
// Register-file bus between decode/writeback and the register file:
// read ports, writeback, issue/flush scoreboard controls and busy count.
interface gp_regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              rd_busy_a;
   logic              rd_busy_b;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              iss_en;
   logic [ADDR_W-1:0] iss_addr;
   logic              flush;
   logic [ADDR_W:0]   busy_cnt;

   modport master (
      output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
      input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, busy_cnt
   );

   modport slave (
      input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
      output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, busy_cnt
   );
endinterface

// File: rtl/gp_regfile_sb.sv
// General-purpose register file, 2 async read ports / 1 write port, with
// optional write->read bypass, hardwired R0 and a pending-write scoreboard.
module gp_regfile_sb_rport #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
   input  logic [(2**ADDR_W)-1:0]             busy,
   input  logic [ADDR_W-1:0]                  addr,
   input  logic                               wr_en,
   input  logic [ADDR_W-1:0]                  wr_addr,
   input  logic [DATA_W-1:0]                  wr_data,
   input  logic                               iss_en,
   input  logic [ADDR_W-1:0]                  iss_addr,
   output logic [DATA_W-1:0]                  data,
   output logic                               busy_out
);
   logic zero_hit;
   logic byp_hit;
   logic iss_hit;

   assign zero_hit = ZERO_REG && (addr == '0);
   assign byp_hit  = BYPASS && wr_en && (wr_addr == addr) && !zero_hit;
   assign iss_hit  = iss_en && (iss_addr == addr);

   always_comb begin
      data = regs[addr];
      if (zero_hit)
         data = '0;
      else if (byp_hit)
         data = wr_data;
   end

   // Bypassed data is valid now unless a newer producer is issuing this cycle.
   assign busy_out = busy[addr] && !(byp_hit && !iss_hit);
endmodule

module gp_regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input logic          clk,
   input logic          rst_n,
   gp_regfile_sb_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int CW    = ADDR_W + 1;
   localparam int NPORT = 2;

   logic [DEPTH-1:0][DATA_W-1:0] regs;
   logic [DEPTH-1:0]             busy;
   logic [DEPTH-1:0]             busy_nxt;
   logic [CW-1:0]                cnt;
   logic [CW-1:0]                cnt_nxt;

   logic wr_ok;
   logic iss_ok;
   logic set_new;
   logic clr_old;

   logic [NPORT-1:0][ADDR_W-1:0] rp_addr;
   logic [NPORT-1:0][DATA_W-1:0] rp_data;
   logic [NPORT-1:0]             rp_busy;

   assign wr_ok  = bus.wr_en  && !(ZERO_REG && (bus.wr_addr  == '0));
   assign iss_ok = bus.iss_en && !(ZERO_REG && (bus.iss_addr == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         regs <= '0;
      else if (wr_ok)
         regs[bus.wr_addr] <= bus.wr_data;
   end

   // Priority per register: flush, then issue (newer producer), then writeback.
   always_comb begin
      busy_nxt = busy;
      for (int r = 0; r < DEPTH; r++) begin
         if (bus.flush)
            busy_nxt[r] = 1'b0;
         else if (iss_ok && (bus.iss_addr == ADDR_W'(r)))
            busy_nxt[r] = 1'b1;
         else if (wr_ok && (bus.wr_addr == ADDR_W'(r)))
            busy_nxt[r] = 1'b0;
      end
      if (ZERO_REG)
         busy_nxt[0] = 1'b0;
   end

   // Count tracks popcount(busy) incrementally; set and clear on different
   // registers in one cycle cancel out.
   assign set_new = iss_ok && !busy[bus.iss_addr];
   assign clr_old = wr_ok && busy[bus.wr_addr] &&
                    !(iss_ok && (bus.iss_addr == bus.wr_addr));

   always_comb begin
      cnt_nxt = cnt;
      if (bus.flush)
         cnt_nxt = '0;
      else if (set_new && !clr_old)
         cnt_nxt = cnt + CW'(1);
      else if (clr_old && !set_new)
         cnt_nxt = cnt - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
         cnt  <= '0;
      end else begin
         busy <= busy_nxt;
         cnt  <= cnt_nxt;
      end
   end

   assign bus.busy_cnt = cnt;

   assign rp_addr[0] = bus.rd_addr_a;
   assign rp_addr[1] = bus.rd_addr_b;

   for (genvar p = 0; p < NPORT; p++) begin : g_rport
      gp_regfile_sb_rport #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_rport (
         .regs     (regs),
         .busy     (busy),
         .addr     (rp_addr[p]),
         .wr_en    (bus.wr_en),
         .wr_addr  (bus.wr_addr),
         .wr_data  (bus.wr_data),
         .iss_en   (bus.iss_en),
         .iss_addr (bus.iss_addr),
         .data     (rp_data[p]),
         .busy_out (rp_busy[p])
      );
   end

   assign bus.rd_data_a = rp_data[0];
   assign bus.rd_data_b = rp_data[1];
   assign bus.rd_busy_a = rp_busy[0];
   assign bus.rd_busy_b = rp_busy[1];
endmodule
